// File: rtl/seg_cal_arbiter.sv
// Round-robin arbiter feeding one shared 10-row segment compressor through a
// two-register pipeline (operand register, result register) with valid/ready return.
module seg_cal_arbiter #(
   parameter int SEG_W = 18,
   parameter int N_REQ = 4,
   parameter int ID_W  = 2
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [N_REQ-1:0]          req_valid,
   output logic [N_REQ-1:0]          req_ready,
   input  logic [N_REQ*10*SEG_W-1:0] req_rows,
   input  logic                      drain,
   output logic                      rsp_valid,
   input  logic                      rsp_ready,
   output logic [ID_W-1:0]           rsp_id,
   output logic [SEG_W+4:0]          rsp_result,
   output logic [15:0]               rsp_count,
   output logic                      idle
);
   localparam int ROWS_W = 10 * SEG_W;
   localparam int RES_W  = SEG_W + 5;

   logic              s1_valid_q, s1_valid_d;
   logic [ID_W-1:0]   s1_id_q, s1_id_d;
   logic [ROWS_W-1:0] s1_rows_q;
   logic              rsp_valid_q, rsp_valid_d;
   logic [ID_W-1:0]   rsp_id_q, rsp_id_d;
   logic [RES_W-1:0]  rsp_result_q, rsp_result_d;
   logic [15:0]       count_q, count_d;
   logic [ID_W-1:0]   ptr_q, ptr_d;

   logic              s2_free, s1_adv, s1_free, grant_en;
   logic              hi_found;
   logic [ID_W-1:0]   lo_idx, hi_idx, gnt_idx;
   logic [ROWS_W-1:0] gnt_rows;
   logic [RES_W-1:0]  comp_sum;

   // Rows are zero-extended; 10*(2^SEG_W-1) always fits in SEG_W+5 bits.
   function automatic logic [RES_W-1:0] compress10(input logic [ROWS_W-1:0] rows);
      logic [RES_W-1:0] acc;
      acc = '0;
      for (int k = 0; k < 10; k++) begin
         acc = acc + RES_W'(rows[k*SEG_W +: SEG_W]);
      end
      return acc;
   endfunction

   assign s2_free  = !rsp_valid_q || rsp_ready;
   assign s1_adv   = s1_valid_q && s2_free;
   assign s1_free  = !s1_valid_q || s1_adv;
   assign grant_en = !rst && s1_free && !drain && (|req_valid);
   assign comp_sum = compress10(s1_rows_q);

   // Lowest valid index above ptr wins; otherwise wrap to lowest valid index.
   always_comb begin
      hi_found = 1'b0;
      lo_idx   = '0;
      hi_idx   = '0;
      for (int i = N_REQ - 1; i >= 0; i--) begin
         if (req_valid[i]) begin
            lo_idx = ID_W'(i);
            if (ID_W'(i) > ptr_q) begin
               hi_idx   = ID_W'(i);
               hi_found = 1'b1;
            end
         end
      end
      gnt_idx = hi_found ? hi_idx : lo_idx;
   end

   always_comb begin
      req_ready = '0;
      gnt_rows  = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (gnt_idx == ID_W'(i)) begin
            req_ready[i] = grant_en;
            gnt_rows     = req_rows[i*ROWS_W +: ROWS_W];
         end
      end
   end

   always_comb begin
      s1_valid_d   = s1_valid_q;
      s1_id_d      = s1_id_q;
      ptr_d        = ptr_q;
      rsp_valid_d  = rsp_valid_q;
      rsp_id_d     = rsp_id_q;
      rsp_result_d = rsp_result_q;
      count_d      = count_q;
      if (grant_en) begin
         s1_valid_d = 1'b1;
         s1_id_d    = gnt_idx;
         ptr_d      = gnt_idx;
      end else if (s1_adv) begin
         s1_valid_d = 1'b0;
      end
      if (s1_adv) begin
         rsp_valid_d  = 1'b1;
         rsp_id_d     = s1_id_q;
         rsp_result_d = comp_sum;
      end else if (rsp_ready && rsp_valid_q) begin
         rsp_valid_d = 1'b0;
      end
      if (rsp_valid_q && rsp_ready) begin
         count_d = count_q + 16'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid_q   <= 1'b0;
         s1_id_q      <= '0;
         ptr_q        <= ID_W'(N_REQ - 1);
         rsp_valid_q  <= 1'b0;
         rsp_id_q     <= '0;
         rsp_result_q <= '0;
         count_q      <= '0;
      end else begin
         s1_valid_q   <= s1_valid_d;
         s1_id_q      <= s1_id_d;
         ptr_q        <= ptr_d;
         rsp_valid_q  <= rsp_valid_d;
         rsp_id_q     <= rsp_id_d;
         rsp_result_q <= rsp_result_d;
         count_q      <= count_d;
      end
   end

   // Operand data needs no reset; s1_valid qualifies it.
   always_ff @(posedge clk) begin
      if (grant_en) begin
         s1_rows_q <= gnt_rows;
      end
   end

   assign rsp_valid  = rsp_valid_q;
   assign rsp_id     = rsp_id_q;
   assign rsp_result = rsp_result_q;
   assign rsp_count  = count_q;
   assign idle       = !s1_valid_q && !rsp_valid_q && !(|req_ready);

endmodule

// File: tb/tb_seg_cal_arbiter.sv
// Directed bench for seg_cal_arbiter: expected responses are queued at grant time
// and a negedge monitor pops and compares every delivered response.
module tb_seg_cal_arbiter;
   localparam int SEG_W = 18;
   localparam int N_REQ = 4;
   localparam int ID_W  = 2;
   localparam int RES_W = SEG_W + 5;

   logic                      clk;
   logic                      rst;
   logic [N_REQ-1:0]          req_valid;
   logic [N_REQ-1:0]          req_ready;
   logic [N_REQ*10*SEG_W-1:0] req_rows;
   logic                      drain;
   logic                      rsp_valid;
   logic                      rsp_ready;
   logic [ID_W-1:0]           rsp_id;
   logic [RES_W-1:0]          rsp_result;
   logic [15:0]               rsp_count;
   logic                      idle;

   int n_checks = 0;
   int n_fail   = 0;
   int hs;
   logic [ID_W+RES_W-1:0] exp_q[$];
   logic [ID_W+RES_W-1:0] mon_exp;

   seg_cal_arbiter #(.SEG_W(SEG_W), .N_REQ(N_REQ), .ID_W(ID_W)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
      .req_rows(req_rows), .drain(drain), .rsp_valid(rsp_valid),
      .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_result(rsp_result),
      .rsp_count(rsp_count), .idle(idle)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic push(input int id, input int val);
      exp_q.push_back({ID_W'(id), RES_W'(val)});
   endtask

   task automatic set_rows(input int r, input logic [SEG_W-1:0] v);
      for (int k = 0; k < 10; k++) req_rows[(r*10+k)*SEG_W +: SEG_W] = v;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   always @(negedge clk) begin
      if (!rst && rsp_valid && rsp_ready) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL rsp_unexpected: got id %0d result 0x%0h, expected no response", rsp_id, rsp_result);
         end else begin
            mon_exp = exp_q.pop_front();
            check("rsp_id_result", 64'({rsp_id, rsp_result}), 64'(mon_exp));
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout, expected end of test");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst = 1'b1; req_valid = '1; req_rows = '0; drain = 1'b0; rsp_ready = 1'b1;
      @(negedge clk);
      check("reset_req_ready", 64'(req_ready), 64'(0));
      step();
      rst = 1'b0; req_valid = '0;
      @(negedge clk);
      check("reset_rsp_valid", 64'(rsp_valid), 64'(0));
      check("reset_rsp_count", 64'(rsp_count), 64'(0));
      check("reset_rsp_id", 64'(rsp_id), 64'(0));
      check("reset_rsp_result", 64'(rsp_result), 64'(0));
      check("reset_idle", 64'(idle), 64'(1));

      // single request from requester 2
      step();
      set_rows(2, 18'h3FFFF); req_valid = 4'b0100;
      @(negedge clk);
      check("single_grant", 64'(req_ready), 64'(4'b0100));
      push(2, 32'h27FFF6);
      step();
      req_valid = '0;
      @(negedge clk);
      check("single_lat_s1", 64'(rsp_valid), 64'(0));
      step();
      @(negedge clk);
      check("single_lat_s2", 64'(rsp_valid), 64'(1));
      step();
      @(negedge clk);
      check("single_count", 64'(rsp_count), 64'(1));
      check("single_idle", 64'(idle), 64'(1));

      // round robin with all requesters valid
      step(); rst = 1'b1; step(); rst = 1'b0;
      for (int i = 0; i < N_REQ; i++) set_rows(i, SEG_W'(i + 1));
      req_valid = '1;
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         check("rr_grant", 64'(req_ready), 64'(1) << (c % 4));
         push(c % 4, 10 * ((c % 4) + 1));
         if (c >= 2) check("rr_rsp_valid", 64'(rsp_valid), 64'(1));
         step();
      end
      req_valid = '0;
      repeat (3) step();
      @(negedge clk);
      check("rr_all_delivered", 64'(exp_q.size()), 64'(0));

      // back-pressure from requester 1
      step();
      rsp_ready = 1'b0; set_rows(1, 18'd5); req_valid = 4'b0010;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         check("bp_ready", 64'(req_ready), (c < 2) ? 64'(4'b0010) : 64'(0));
         if (c == 0) push(1, 50);
         if (c == 1) push(1, 70);
         if (c >= 2) begin
            check("bp_hold_valid", 64'(rsp_valid), 64'(1));
            check("bp_hold_id", 64'(rsp_id), 64'(1));
            check("bp_hold_result", 64'(rsp_result), 64'(50));
         end
         step();
         if (c == 0) set_rows(1, 18'd7);
         if (c == 1) set_rows(1, 18'd9);
      end
      req_valid = '0; rsp_ready = 1'b1;
      repeat (3) step();
      @(negedge clk);
      check("bp_no_loss", 64'(exp_q.size()), 64'(0));

      // drain with two operands in flight
      step();
      rsp_ready = 1'b0; set_rows(3, 18'd1); req_valid = 4'b1000;
      @(negedge clk);
      check("drain_fill0", 64'(req_ready), 64'(4'b1000));
      push(3, 10);
      step();
      set_rows(3, 18'd2);
      @(negedge clk);
      check("drain_fill1", 64'(req_ready), 64'(4'b1000));
      push(3, 20);
      step();
      drain = 1'b1; rsp_ready = 1'b1; set_rows(3, 18'd3);
      for (int c = 2; c < 7; c++) begin
         @(negedge clk);
         check("drain_no_grant", 64'(req_ready), 64'(0));
         if (c >= 4) check("drain_idle", 64'(idle), 64'(1));
         step();
      end
      drain = 1'b0; req_valid = '0;
      @(negedge clk);
      check("drain_delivered", 64'(exp_q.size()), 64'(0));

      // reset with both stages full
      step();
      rsp_ready = 1'b0; set_rows(2, 18'd4); req_valid = 4'b0100;
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         check("rst_fill", 64'(req_ready), 64'(4'b0100));
         step();
      end
      @(negedge clk);
      check("rst_s2_full", 64'(rsp_valid), 64'(1));
      step();
      rst = 1'b1;
      @(negedge clk);
      check("rst_cycle_ready", 64'(req_ready), 64'(0));
      step();
      rst = 1'b0; req_valid = '1; rsp_ready = 1'b1;
      for (int i = 0; i < N_REQ; i++) set_rows(i, SEG_W'(i + 1));
      @(negedge clk);
      check("rst_rsp_valid", 64'(rsp_valid), 64'(0));
      check("rst_rsp_count", 64'(rsp_count), 64'(0));
      check("rst_first_grant", 64'(req_ready), 64'(4'b0001));
      push(0, 10);
      step();
      req_valid = '0;
      repeat (3) step();
      @(negedge clk);
      check("rst_after_delivered", 64'(exp_q.size()), 64'(0));

      // counter wrap
      step(); rst = 1'b1; step(); rst = 1'b0;
      set_rows(0, 18'h3FFFF); req_valid = 4'b0001; hs = 0;
      for (int n = 0; n < 65537; n++) begin
         @(negedge clk);
         if (req_ready[0]) begin
            hs++;
            push(0, 32'h27FFF6);
         end
         step();
      end
      req_valid = '0;
      repeat (3) step();
      @(negedge clk);
      check("wrap_handshakes", 64'(hs), 64'(65537));
      check("wrap_count", 64'(rsp_count), 64'(1));
      check("wrap_delivered", 64'(exp_q.size()), 64'(0));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
